// File: rtl/sensor_ae_ctrl.sv
// sensor_ae_ctrl: frame-based auto-exposure loop.
// Steers exp_out so the frame gray sum settles inside [target_lo, target_hi].
module sensor_ae_ctrl #(
    parameter int unsigned SKIP_FRAMES  = 2,
    parameter int unsigned COARSE_SHIFT = 2,
    parameter string       DEBUG        = "FALSE"
) (
    input  logic        px_clk,
    input  logic        px_reset,
    input  logic        enable,
    input  logic        vs_in,
    input  logic [31:0] gray_sum_L_in,
    input  logic [31:0] gray_sum_H_in,
    input  logic [39:0] target_lo,
    input  logic [39:0] target_hi,
    input  logic [31:0] exp_min,
    input  logic [31:0] exp_max,
    input  logic [31:0] exp_init,
    input  logic [15:0] exp_step,
    output logic [31:0] exp_out,
    output logic        exp_update,
    output logic        locked,
    output logic [2:0]  state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CAPTURE = 3'd2,
        S_COMPUTE = 3'd3,
        S_SETTLE  = 3'd4
    } state_t;

    localparam logic [3:0] SKIP_INIT = 4'(SKIP_FRAMES);
    localparam bit         DBG       = (DEBUG == "TRUE");

    state_t      state;
    logic        vs_r;
    logic        fe;
    logic [3:0]  skip_cnt;
    logic [39:0] sum;

    logic [40:0] sum41;
    logic [40:0] lo_half;
    logic [40:0] hi_dbl;
    logic        below;
    logic        above;
    logic        coarse;
    logic [33:0] fine_step;
    logic [33:0] step;
    logic [33:0] inc;
    logic [33:0] dec;
    logic [31:0] exp_next;
    logic [31:0] init_clamped;
    logic        unused_gray_hi;

    // bit 33 set means the subtraction went below zero
    function automatic logic [31:0] clamp(
        input logic [33:0] v,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (lo > hi)
            return hi;
        else if (v[33] || v < {2'b00, lo})
            return lo;
        else if (v > {2'b00, hi})
            return hi;
        else
            return v[31:0];
    endfunction

    assign fe             = vs_r & ~vs_in;
    assign unused_gray_hi = ^gray_sum_H_in[31:8];

    assign sum41   = {1'b0, sum};
    assign lo_half = {2'b00, target_lo[39:1]};
    assign hi_dbl  = {target_hi, 1'b0};
    assign below   = sum < target_lo;
    assign above   = sum > target_hi;
    assign coarse  = (sum41 < lo_half) || (sum41 > hi_dbl);

    assign fine_step = {18'd0, exp_step};
    assign step      = coarse ? (fine_step << COARSE_SHIFT) : fine_step;
    assign inc       = {2'b00, exp_out} + step;
    assign dec       = {2'b00, exp_out} - step;
    assign exp_next  = below ? clamp(inc, exp_min, exp_max)
                             : clamp(dec, exp_min, exp_max);

    assign init_clamped = clamp({2'b00, exp_init}, exp_min, exp_max);

    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            state      <= S_IDLE;
            exp_out    <= '0;
            exp_update <= 1'b0;
            locked     <= 1'b0;
            skip_cnt   <= '0;
            vs_r       <= 1'b0;
            sum        <= '0;
        end else begin
            vs_r       <= vs_in;
            exp_update <= 1'b0;
            if (!enable) begin
                state  <= S_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        exp_out    <= init_clamped;
                        exp_update <= 1'b1;
                        skip_cnt   <= SKIP_INIT;
                        state      <= S_SETTLE;
                    end
                    S_WAIT: begin
                        if (fe)
                            state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        sum   <= {gray_sum_H_in[7:0], gray_sum_L_in};
                        state <= S_COMPUTE;
                    end
                    S_COMPUTE: begin
                        if (below || above) begin
                            locked <= 1'b0;
                            if (exp_next != exp_out) begin
                                exp_out    <= exp_next;
                                exp_update <= 1'b1;
                                skip_cnt   <= SKIP_INIT;
                                state      <= S_SETTLE;
                            end else begin
                                state <= S_WAIT;
                            end
                        end else begin
                            locked <= 1'b1;
                            state  <= S_WAIT;
                        end
                    end
                    S_SETTLE: begin
                        if (skip_cnt == 4'd0)
                            state <= S_WAIT;
                        else if (fe)
                            skip_cnt <= skip_cnt - 4'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    if (DBG) begin : g_dbg
        assign state_out = state;
    end else begin : g_nodbg
        assign state_out = 3'd0;
    end

endmodule

// File: tb/tb_sensor_ae_ctrl.sv
// tb_sensor_ae_ctrl: directed vector table, hand sequences and a
// frame-level reference model driven by random frames.
`timescale 1ns/1ps
module tb_sensor_ae_ctrl;

    localparam int SKIP   = 2;
    localparam int COARSE = 2;
    localparam logic [39:0] BIG = 40'h12_3456_7890;

    logic        px_clk = 1'b0;
    logic        px_reset;
    logic        enable;
    logic        vs_in;
    logic [31:0] gray_sum_L_in;
    logic [31:0] gray_sum_H_in;
    logic [39:0] target_lo;
    logic [39:0] target_hi;
    logic [31:0] exp_min;
    logic [31:0] exp_max;
    logic [31:0] exp_init;
    logic [15:0] exp_step;
    logic [31:0] exp_out;
    logic        exp_update;
    logic        locked;
    logic [2:0]  state_out;

    int n_chk = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    longint m_exp;
    bit     m_locked;
    int     m_skip;

    typedef struct {
        logic [39:0] sum;
        logic [31:0] exp;
        logic        lk;
        int          pls;
        logic [2:0]  st;
    } vec_t;

    vec_t tbl[16];

    sensor_ae_ctrl #(
        .SKIP_FRAMES (SKIP),
        .COARSE_SHIFT(COARSE),
        .DEBUG       ("TRUE")
    ) dut (
        .px_clk       (px_clk),
        .px_reset     (px_reset),
        .enable       (enable),
        .vs_in        (vs_in),
        .gray_sum_L_in(gray_sum_L_in),
        .gray_sum_H_in(gray_sum_H_in),
        .target_lo    (target_lo),
        .target_hi    (target_hi),
        .exp_min      (exp_min),
        .exp_max      (exp_max),
        .exp_init     (exp_init),
        .exp_step     (exp_step),
        .exp_out      (exp_out),
        .exp_update   (exp_update),
        .locked       (locked),
        .state_out    (state_out)
    );

    always #5 px_clk = ~px_clk;

    always @(negedge px_clk)
        if (exp_update === 1'b1)
            pulse_cnt++;

    task automatic tick();
        @(posedge px_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input logic [39:0] s, output int pulses);
        int p0;
        p0 = pulse_cnt;
        gray_sum_L_in = s[31:0];
        gray_sum_H_in = $urandom();
        gray_sum_H_in[7:0] = s[39:32];
        vs_in = 1'b1;
        repeat (6) tick();
        vs_in = 1'b0;
        repeat (6) tick();
        pulses = pulse_cnt - p0;
    endtask

    function automatic longint m_clamp(input longint v);
        longint mn;
        longint mx;
        mn = exp_min;
        mx = exp_max;
        if (mn > mx) return mx;
        if (v < mn) return mn;
        if (v > mx) return mx;
        return v;
    endfunction

    task automatic m_init();
        m_exp    = m_clamp(exp_init);
        m_skip   = SKIP;
        m_locked = 1'b0;
    endtask

    task automatic m_frame(input longint s, output int pulse);
        longint st;
        longint nv;
        longint lo;
        longint hi;
        pulse = 0;
        lo = target_lo;
        hi = target_hi;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        if (s >= lo && s <= hi) begin
            m_locked = 1'b1;
            return;
        end
        st = exp_step;
        if (s < lo / 2 || s > hi * 2)
            st = st * (1 << COARSE);
        m_locked = 1'b0;
        nv = (s < lo) ? m_clamp(m_exp + st) : m_clamp(m_exp - st);
        if (nv != m_exp) begin
            m_exp  = nv;
            pulse  = 1;
            m_skip = SKIP;
        end
    endtask

    function automatic longint rnd_range(input longint a, input longint b);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return a + longint'(r[62:0] % (b - a + 1));
    endfunction

    task automatic new_targets();
        longint lo;
        longint hi;
        lo = rnd_range(1, 64'sd1 << 33);
        hi = lo + rnd_range(0, 64'sd1 << 32);
        target_lo = lo[39:0];
        target_hi = hi[39:0];
    endtask

    function automatic logic [39:0] pick_sum();
        longint lo;
        longint hi;
        longint c[8];
        longint s;
        lo = target_lo;
        hi = target_hi;
        case ($urandom_range(0, 4))
            0: s = rnd_range(0, lo);
            1: s = rnd_range(lo, hi);
            2: s = rnd_range(hi, hi * 2 + 2);
            3: s = rnd_range(0, (64'sd1 << 40) - 1);
            default: begin
                c = '{lo / 2 - 1, lo / 2, lo - 1, lo,
                      hi, hi + 1, hi * 2, hi * 2 + 1};
                s = c[$urandom_range(0, 7)];
                if (s < 0) s = 0;
            end
        endcase
        return s[39:0];
    endfunction

    initial begin
        int p;
        int ep;
        logic [39:0] s;

        tbl[0]  = '{BIG,            32'd1000, 1'b0, 0, 3'd4};
        tbl[1]  = '{BIG,            32'd1000, 1'b0, 0, 3'd1};
        tbl[2]  = '{40'd400,        32'd1040, 1'b0, 1, 3'd4};
        tbl[3]  = '{BIG,            32'd1040, 1'b0, 0, 3'd4};
        tbl[4]  = '{BIG,            32'd1040, 1'b0, 0, 3'd1};
        tbl[5]  = '{40'd5000,       32'd1000, 1'b0, 1, 3'd4};
        tbl[6]  = '{BIG,            32'd1000, 1'b0, 0, 3'd4};
        tbl[7]  = '{BIG,            32'd1000, 1'b0, 0, 3'd1};
        tbl[8]  = '{40'd5000,       32'd960,  1'b0, 1, 3'd4};
        tbl[9]  = '{BIG,            32'd960,  1'b0, 0, 3'd4};
        tbl[10] = '{BIG,            32'd960,  1'b0, 0, 3'd1};
        tbl[11] = '{40'd900,        32'd970,  1'b0, 1, 3'd4};
        tbl[12] = '{BIG,            32'd970,  1'b0, 0, 3'd4};
        tbl[13] = '{BIG,            32'd970,  1'b0, 0, 3'd1};
        tbl[14] = '{40'd1500,       32'd970,  1'b1, 0, 3'd1};
        tbl[15] = '{40'd2500,       32'd960,  1'b0, 1, 3'd4};

        px_reset = 1'b1;
        enable = 1'b0;
        vs_in = 1'b0;
        gray_sum_L_in = '0;
        gray_sum_H_in = '0;
        target_lo = 40'd1000;
        target_hi = 40'd2000;
        exp_min = 32'd100;
        exp_max = 32'd5000;
        exp_init = 32'd1000;
        exp_step = 16'd10;
        repeat (3) tick();
        chk("rst_exp", exp_out, 0);
        chk("rst_upd", exp_update, 0);
        chk("rst_lock", locked, 0);
        chk("rst_state", state_out, 0);

        enable = 1'b1;
        tick();
        chk("rst_hold_exp", exp_out, 0);
        chk("rst_hold_state", state_out, 0);

        px_reset = 1'b0;
        tick();
        chk("init_exp", exp_out, 1000);
        chk("init_upd", exp_update, 1);
        chk("init_state", state_out, 4);
        tick();
        chk("init_upd_clr", exp_update, 0);

        for (int i = 0; i < 16; i++) begin
            run_frame(tbl[i].sum, p);
            chk($sformatf("tbl%0d_exp", i), exp_out, tbl[i].exp);
            chk($sformatf("tbl%0d_lock", i), locked, tbl[i].lk);
            chk($sformatf("tbl%0d_pulse", i), p, tbl[i].pls);
            chk($sformatf("tbl%0d_state", i), state_out, tbl[i].st);
        end

        enable = 1'b0;
        tick();
        chk("dis_state", state_out, 0);
        chk("dis_exp", exp_out, 960);
        chk("dis_lock", locked, 0);

        exp_init = 32'd4995;
        enable = 1'b1;
        tick();
        chk("sat_init", exp_out, 4995);
        tick();
        run_frame(BIG, p);
        run_frame(BIG, p);
        run_frame(40'd900, p);
        chk("sat_exp", exp_out, 5000);
        chk("sat_pulse", p, 1);
        run_frame(BIG, p);
        chk("skip1_state", state_out, 4);
        chk("skip1_exp", exp_out, 5000);
        run_frame(BIG, p);
        chk("skip2_state", state_out, 1);
        run_frame(40'd900, p);
        chk("sat2_exp", exp_out, 5000);
        chk("sat2_pulse", p, 0);
        chk("sat2_lock", locked, 0);
        chk("sat2_state", state_out, 1);

        run_frame(40'd1500, p);
        chk("lock_lock", locked, 1);
        chk("lock_pulse", p, 0);

        gray_sum_L_in = 32'd1500;
        vs_in = 1'b1;
        repeat (4) tick();
        vs_in = 1'b0;
        tick();
        chk("mid_capture", state_out, 2);
        px_reset = 1'b1;
        tick();
        chk("mid_rst_exp", exp_out, 0);
        chk("mid_rst_upd", exp_update, 0);
        chk("mid_rst_lock", locked, 0);
        chk("mid_rst_state", state_out, 0);
        exp_init = 32'd1234;
        px_reset = 1'b0;
        tick();
        chk("rel_exp", exp_out, 1234);
        chk("rel_upd", exp_update, 1);
        chk("rel_state", state_out, 4);
        tick();

        enable = 1'b0;
        tick();
        exp_min = 32'd3000;
        exp_max = 32'd2000;
        exp_init = 32'd100;
        enable = 1'b1;
        tick();
        chk("inv_clamp", exp_out, 2000);
        tick();

        for (int k = 0; k < 8; k++) begin
            enable = 1'b0;
            exp_min = $urandom_range(0, 2000);
            exp_max = exp_min + $urandom_range(0, 4000);
            exp_init = $urandom_range(0, 7000);
            exp_step = (k < 4) ? 16'($urandom_range(0, 300))
                               : 16'($urandom_range(0, 65535));
            if (k == 5) begin
                exp_min = 0;
                exp_max = 1000;
            end
            if (k == 6) begin
                exp_min = 32'hFFFF_F000;
                exp_max = 32'hFFFF_FFFF;
                exp_init = $urandom();
            end
            if (k == 7) begin
                exp_min = 3000;
                exp_max = 1000;
            end
            new_targets();
            tick();
            enable = 1'b1;
            tick();
            m_init();
            chk($sformatf("rnd%0d_init", k), exp_out, m_exp);
            tick();
            for (int f = 0; f < 14; f++) begin
                if ($urandom_range(0, 4) == 0) begin
                    new_targets();
                    exp_step = $urandom_range(0, 65535);
                end
                s = pick_sum();
                run_frame(s, p);
                m_frame(longint'(s), ep);
                chk($sformatf("rnd%0d_%0d_exp", k, f), exp_out, m_exp);
                chk($sformatf("rnd%0d_%0d_lock", k, f), locked, m_locked);
                chk($sformatf("rnd%0d_%0d_pulse", k, f), p, ep);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
